branch_hist_feat: RTL and testbench

BRANCH_HIST_FEAT -- requirements
Module: branch_hist_feat

---
 rtl/branch_hist_feat.sv | 106 ++++++++++
 tb/tb_branch_hist_feat.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_hist_feat.sv
// Global-history feature generator: speculative and architectural branch history
// plus an in-order queue of in-flight branches that produces predictor training payloads.
module branch_hist_feat #(
    parameter int unsigned FEATURES = 32,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_valid,
    input  logic [31:0]           fetch_pc,
    input  logic                  pred_taken,
    output logic                  fetch_ready,
    output logic [FEATURES-1:0]   predict_features,
    input  logic                  resolve_valid,
    input  logic                  resolve_taken,
    input  logic                  flush,
    output logic                  train_en,
    output logic [31:0]           train_pc,
    output logic [FEATURES-1:0]   train_features,
    output logic                  actual_taken,
    output logic                  mispredict,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]          pc_mem   [DEPTH];
    logic [FEATURES-1:0]  ghr_mem  [DEPTH];
    logic                 pred_mem [DEPTH];

    logic [PW-1:0]        head;
    logic [PW-1:0]        tail;
    logic [FEATURES-1:0]  arch_ghr;
    logic [FEATURES-1:0]  spec_ghr;

    logic                 pop;
    logic                 mis;
    logic                 kill;
    logic                 push;
    logic [FEATURES-1:0]  arch_next;

    assign fetch_ready      = (count < CW'(DEPTH)) && !rst;
    assign predict_features = spec_ghr;

    // A mispredict or flush squashes everything younger, including a same-cycle push.
    always_comb begin
        pop       = resolve_valid && (count != '0) && !rst;
        mis       = pop && (resolve_taken != pred_mem[head]);
        kill      = mis || flush;
        push      = fetch_valid && fetch_ready && !kill;
        arch_next = arch_ghr;
        if (pop) begin
            arch_next = {arch_ghr[FEATURES-2:0], resolve_taken};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= fetch_pc;
            ghr_mem[tail]  <= spec_ghr;
            pred_mem[tail] <= pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arch_ghr       <= '0;
            spec_ghr       <= '0;
            count          <= '0;
            head           <= '0;
            tail           <= '0;
            train_en       <= 1'b0;
            mispredict     <= 1'b0;
            train_pc       <= '0;
            train_features <= '0;
            actual_taken   <= 1'b0;
        end else begin
            train_en   <= pop;
            mispredict <= mis;
            arch_ghr   <= arch_next;
            if (pop) begin
                train_pc       <= pc_mem[head];
                train_features <= ghr_mem[head];
                actual_taken   <= resolve_taken;
            end
            if (kill) begin
                // Restart speculation from the committed history.
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                spec_ghr <= arch_next;
            end else begin
                if (push) begin
                    tail     <= tail + PW'(1);
                    spec_ghr <= {spec_ghr[FEATURES-2:0], pred_taken};
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_branch_hist_feat.sv
// Directed bench for branch_hist_feat (FEATURES=32, DEPTH=8).
module tb_branch_hist_feat;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        fetch_ready;
    logic [31:0] predict_features;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        flush;
    logic        train_en;
    logic [31:0] train_pc;
    logic [31:0] train_features;
    logic        actual_taken;
    logic        mispredict;
    logic [3:0]  count;

    int checks = 0;
    int errors = 0;

    logic [31:0] ghr [0:21];

    branch_hist_feat #(.FEATURES(32), .DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .fetch_ready(fetch_ready), .predict_features(predict_features),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .flush(flush),
        .train_en(train_en), .train_pc(train_pc), .train_features(train_features),
        .actual_taken(actual_taken), .mispredict(mispredict), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic pred_of(input int n);
        return (n % 3) == 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of stimulus, then return inputs to idle.
    task automatic do_cycle(input logic fv, input logic [31:0] pc, input logic pt,
                            input logic rv, input logic rt, input logic fl);
        fetch_valid = fv; fetch_pc = pc; pred_taken = pt;
        resolve_valid = rv; resolve_taken = rt; flush = fl;
        step();
        fetch_valid = 0; fetch_pc = '0; pred_taken = 0;
        resolve_valid = 0; resolve_taken = 0; flush = 0;
    endtask

    task automatic apply_reset();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; fetch_valid = 1; fetch_pc = 32'hdead; pred_taken = 1;
        resolve_valid = 1; resolve_taken = 1; flush = 0;
        step(); step();
        fetch_valid = 0; fetch_pc = '0; pred_taken = 0; resolve_valid = 0; resolve_taken = 0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", fetch_ready); end
        checks++; if (train_en !== 1'b0) begin errors++; $display("FAIL reset_train_en: got %b expected 0", train_en); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict: got %b expected 0", mispredict); end
        checks++; if (predict_features !== 32'h0) begin errors++; $display("FAIL reset_features: got %h expected 0", predict_features); end
        rst = 0;
        #1;
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", fetch_ready); end
    endtask

    task automatic test_push_basic();
        do_cycle(1, 32'h100, 1, 0, 0, 0);
        checks++; if (predict_features !== 32'h1) begin errors++; $display("FAIL push1_features: got %h expected 1", predict_features); end
        do_cycle(1, 32'h104, 0, 0, 0, 0);
        checks++; if (predict_features !== 32'h2) begin errors++; $display("FAIL push2_features: got %h expected 2", predict_features); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL push2_count: got %0d expected 2", count); end
    endtask

    task automatic test_resolve_correct();
        do_cycle(0, 0, 0, 1, 1, 0);
        checks++; if (train_en !== 1'b1) begin errors++; $display("FAIL res1_train_en: got %b expected 1", train_en); end
        checks++; if (train_pc !== 32'h100) begin errors++; $display("FAIL res1_pc: got %h expected 100", train_pc); end
        checks++; if (train_features !== 32'h0) begin errors++; $display("FAIL res1_features: got %h expected 0", train_features); end
        checks++; if (actual_taken !== 1'b1) begin errors++; $display("FAIL res1_actual: got %b expected 1", actual_taken); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL res1_mispredict: got %b expected 0", mispredict); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL res1_count: got %0d expected 1", count); end
        do_cycle(0, 0, 0, 0, 0, 0);
        checks++; if (train_en !== 1'b0) begin errors++; $display("FAIL idle_train_en: got %b expected 0", train_en); end
        checks++; if (train_pc !== 32'h100) begin errors++; $display("FAIL idle_pc_hold: got %h expected 100", train_pc); end
        do_cycle(0, 0, 0, 1, 0, 0);
        checks++; if (train_pc !== 32'h104) begin errors++; $display("FAIL res2_pc: got %h expected 104", train_pc); end
        checks++; if (train_features !== 32'h1) begin errors++; $display("FAIL res2_features: got %h expected 1", train_features); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL res2_count: got %0d expected 0", count); end
    endtask

    task automatic test_resolve_empty();
        do_cycle(0, 0, 0, 1, 1, 0);
        checks++; if (train_en !== 1'b0) begin errors++; $display("FAIL empty_train_en: got %b expected 0", train_en); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL empty_mispredict: got %b expected 0", mispredict); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL empty_count: got %0d expected 0", count); end
    endtask

    task automatic test_mispredict();
        apply_reset();
        // Commit outcomes 1,0,1 so that arch history reads 0x5.
        do_cycle(1, 32'h10, 1, 0, 0, 0); do_cycle(0, 0, 0, 1, 1, 0);
        do_cycle(1, 32'h14, 0, 0, 0, 0); do_cycle(0, 0, 0, 1, 0, 0);
        do_cycle(1, 32'h18, 1, 0, 0, 0); do_cycle(0, 0, 0, 1, 1, 0);
        do_cycle(1, 32'h400, 1, 0, 0, 0);
        do_cycle(1, 32'h404, 1, 0, 0, 0);
        do_cycle(1, 32'h408, 0, 0, 0, 0);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL mis_setup_count: got %0d expected 3", count); end
        checks++; if (predict_features !== 32'h2E) begin errors++; $display("FAIL mis_setup_features: got %h expected 2e", predict_features); end
        do_cycle(1, 32'h40C, 1, 1, 0, 0);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", mispredict); end
        checks++; if (train_en !== 1'b1) begin errors++; $display("FAIL mis_train_en: got %b expected 1", train_en); end
        checks++; if (train_pc !== 32'h400) begin errors++; $display("FAIL mis_pc: got %h expected 400", train_pc); end
        checks++; if (train_features !== 32'h5) begin errors++; $display("FAIL mis_features: got %h expected 5", train_features); end
        checks++; if (actual_taken !== 1'b0) begin errors++; $display("FAIL mis_actual: got %b expected 0", actual_taken); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL mis_count: got %0d expected 0", count); end
        checks++; if (predict_features !== 32'hA) begin errors++; $display("FAIL mis_spec: got %h expected a", predict_features); end
        do_cycle(0, 0, 0, 0, 0, 0);
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL mis_one_cycle: got %b expected 0", mispredict); end
    endtask

    task automatic test_full();
        apply_reset();
        for (int i = 0; i < 8; i++) do_cycle(1, 32'h300 + 32'(4 * i), 0, 0, 0, 0);
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", fetch_ready); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d expected 8", count); end
        do_cycle(1, 32'h500, 0, 1, 0, 0);
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL full_drop_count: got %0d expected 7", count); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL full_drop_ready: got %b expected 1", fetch_ready); end
        checks++; if (train_pc !== 32'h300) begin errors++; $display("FAIL full_first_pc: got %h expected 300", train_pc); end
        for (int i = 1; i < 8; i++) begin
            do_cycle(0, 0, 0, 1, 0, 0);
            checks++;
            if (train_pc !== 32'h300 + 32'(4 * i)) begin
                errors++; $display("FAIL drain_pc[%0d]: got %h expected %h", i, train_pc, 32'h300 + 32'(4 * i));
            end
        end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_cycle(1, 32'h200, pred_of(0), 0, 0, 0);
        for (int n = 1; n <= 20; n++) begin
            do_cycle(1, 32'h200 + 32'(4 * n), pred_of(n), 1, pred_of(n - 1), 0);
            checks++;
            if (train_pc !== 32'h200 + 32'(4 * (n - 1))) begin
                errors++; $display("FAIL b2b_pc[%0d]: got %h expected %h", n, train_pc, 32'h200 + 32'(4 * (n - 1)));
            end
            checks++;
            if (train_features !== ghr[n - 1]) begin
                errors++; $display("FAIL b2b_features[%0d]: got %h expected %h", n, train_features, ghr[n - 1]);
            end
            checks++;
            if (count !== 4'd1 || mispredict !== 1'b0) begin
                errors++; $display("FAIL b2b_count[%0d]: got count %0d mis %b expected count 1 mis 0", n, count, mispredict);
            end
        end
    endtask

    task automatic test_flush();
        do_cycle(1, 32'h600, 1, 1, pred_of(20), 1);
        checks++; if (train_en !== 1'b1) begin errors++; $display("FAIL flush_train_en: got %b expected 1", train_en); end
        checks++; if (train_pc !== 32'h250) begin errors++; $display("FAIL flush_pc: got %h expected 250", train_pc); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        checks++; if (predict_features !== ghr[21]) begin errors++; $display("FAIL flush_spec: got %h expected %h", predict_features, ghr[21]); end
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 5; i++) do_cycle(1, 32'h700 + 32'(4 * i), 1, 0, 0, 0);
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL midrst_setup: got %0d expected 5", count); end
        rst = 1; resolve_valid = 1; resolve_taken = 1; fetch_valid = 1; fetch_pc = 32'h800;
        step();
        resolve_valid = 0; resolve_taken = 0; fetch_valid = 0; fetch_pc = '0;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count); end
        checks++; if (train_en !== 1'b0) begin errors++; $display("FAIL midrst_train_en: got %b expected 0", train_en); end
        checks++; if (predict_features !== 32'h0) begin errors++; $display("FAIL midrst_features: got %h expected 0", predict_features); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", fetch_ready); end
        rst = 0;
        #1;
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready: got %b expected 1", fetch_ready); end
        do_cycle(0, 0, 0, 1, 1, 0);
        checks++; if (train_en !== 1'b0) begin errors++; $display("FAIL midrst_no_train: got %b expected 0", train_en); end
    endtask

    initial begin
        rst = 1; fetch_valid = 0; fetch_pc = '0; pred_taken = 0;
        resolve_valid = 0; resolve_taken = 0; flush = 0;
        ghr[0] = '0;
        for (int n = 0; n < 21; n++) ghr[n + 1] = {ghr[n][30:0], pred_of(n)};

        test_reset();
        test_push_basic();
        test_resolve_correct();
        test_resolve_empty();
        test_mispredict();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_midop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
